// File: rtl/host_word_buffer.sv
// rtl/host_word_buffer.sv - host secret-word entry buffer with backspace, validation and lock
// Optional lowercase folding is compiled in with the UPPERCASE_FOLD_EN macro.
module host_word_buffer #(
    parameter int         WORD_LEN   = 5,
    parameter logic [7:0] BLANK_CHAR = 8'h5F,
    parameter bit         AUTO_LOCK  = 1'b0
) (
    input  logic                            clk,
    input  logic                            nRst,
    input  logic                            key_ready,
    input  logic [7:0]                      key_char,
    input  logic                            backspace,
    input  logic                            toggle_state,
    input  logic                            gameEnd_host,
    output logic                            rec_ready,
    output logic [WORD_LEN*8-1:0]           temp_word,
    output logic [$clog2(WORD_LEN+1)-1:0]   letter_count,
    output logic                            word_full,
    output logic                            key_reject
);

    localparam int             CW        = $clog2(WORD_LEN + 1);
    localparam logic [CW-1:0]  C_ONE     = CW'(1);
    localparam logic [CW-1:0]  C_FULL    = CW'(WORD_LEN);
    localparam logic [CW-1:0]  C_LAST    = CW'(WORD_LEN - 1);
    localparam logic [0:0]     ST_SET    = 1'b0;
    localparam logic [0:0]     ST_LOCKED = 1'b1;

    logic [7:0]    r_slot [WORD_LEN];
    logic [CW-1:0] r_count;
    logic [0:0]    r_state;
    logic          r_key_reject;

    logic          w_is_upper;
    logic          w_key_valid;
    logic [7:0]    w_key_code;
    logic          w_full;

    logic [0:0]    w_next_state;
    logic [CW-1:0] w_next_count;
    logic          w_next_reject;
    logic          w_clear;
    logic          w_wr_en;
    logic [CW-1:0] w_wr_idx;
    logic [7:0]    w_wr_data;

    assign w_is_upper = (key_char >= 8'h41) && (key_char <= 8'h5A);

`ifdef UPPERCASE_FOLD_EN
    logic w_is_lower;
    assign w_is_lower  = (key_char >= 8'h61) && (key_char <= 8'h7A);
    assign w_key_valid = w_is_upper || w_is_lower;
    assign w_key_code  = w_is_lower ? (key_char - 8'h20) : key_char;
`else
    assign w_key_valid = w_is_upper;
    assign w_key_code  = key_char;
`endif

    assign w_full = (r_count == C_FULL);

    always_comb begin
        w_next_state  = r_state;
        w_next_count  = r_count;
        w_next_reject = 1'b0;
        w_clear       = 1'b0;
        w_wr_en       = 1'b0;
        w_wr_idx      = r_count;
        w_wr_data     = BLANK_CHAR;

        if (gameEnd_host) begin
            w_next_state = ST_SET;
            w_next_count = '0;
            w_clear      = 1'b1;
        end else if (r_state == ST_LOCKED) begin
            w_next_reject = key_ready || backspace;
        end else if (backspace) begin
            // a key arriving alongside backspace is dropped and flagged
            w_next_reject = key_ready;
            if (r_count != '0) begin
                w_wr_en      = 1'b1;
                w_wr_idx     = r_count - C_ONE;
                w_wr_data    = BLANK_CHAR;
                w_next_count = r_count - C_ONE;
            end
        end else begin
            if (key_ready) begin
                if (w_key_valid && !w_full) begin
                    w_wr_en      = 1'b1;
                    w_wr_idx     = r_count;
                    w_wr_data    = w_key_code;
                    w_next_count = r_count + C_ONE;
                    if (AUTO_LOCK && (r_count == C_LAST))
                        w_next_state = ST_LOCKED;
                end else begin
                    w_next_reject = 1'b1;
                end
            end
            // toggle judges fullness on the count before any same-cycle key
            if (toggle_state) begin
                if (w_full)
                    w_next_state = ST_LOCKED;
                else
                    w_next_reject = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge nRst) begin
        if (!nRst) begin
            r_state      <= ST_SET;
            r_count      <= '0;
            r_key_reject <= 1'b0;
            for (int i = 0; i < WORD_LEN; i++)
                r_slot[i] <= BLANK_CHAR;
        end else begin
            r_state      <= w_next_state;
            r_count      <= w_next_count;
            r_key_reject <= w_next_reject;
            for (int i = 0; i < WORD_LEN; i++) begin
                if (w_clear)
                    r_slot[i] <= BLANK_CHAR;
                else if (w_wr_en && (w_wr_idx == CW'(i)))
                    r_slot[i] <= w_wr_data;
            end
        end
    end

    for (genvar g = 0; g < WORD_LEN; g++) begin : g_pack
        assign temp_word[(WORD_LEN-g)*8-1 -: 8] = r_slot[g];
    end

    assign rec_ready    = (r_state == ST_LOCKED);
    assign letter_count = r_count;
    assign word_full    = w_full;
    assign key_reject   = r_key_reject;

endmodule
